// File: rtl/rv32i_pkg.sv
// Shared RV32I constants used by the fetch stage and its buffer.
package rv32i_pkg;

    localparam int unsigned     XLEN      = 32;
    localparam int unsigned     ILEN      = 32;
    localparam logic [31:0]     RESET_PC  = 32'h0000_0000;
    localparam logic [31:0]     NOP_INSTR = 32'h0000_0013;

    // Width of the stale-response counter; covers several back-to-back
    // redirects with a deep memory pipeline.
    localparam int unsigned     DISCARD_W = 8;

endpackage

// File: rtl/rv32i_fetch_if.sv
// Fetch-stage bus: imem request/response, execute redirect and decode handshake.
interface rv32i_fetch_if #(
    parameter int unsigned XLEN = rv32i_pkg::XLEN
) ();
    import rv32i_pkg::*;

    logic            imem_req_valid;
    logic            imem_req_ready;
    logic [XLEN-1:0] imem_req_addr;
    logic            imem_rsp_valid;
    logic [ILEN-1:0] imem_rsp_data;
    logic            redirect_valid;
    logic [XLEN-1:0] redirect_pc;
    logic            id_valid;
    logic            id_ready;
    logic [XLEN-1:0] id_pc;
    logic [ILEN-1:0] id_instr;

    // Fetch stage side
    modport master (
        output imem_req_valid, imem_req_addr, id_valid, id_pc, id_instr,
        input  imem_req_ready, imem_rsp_valid, imem_rsp_data,
               redirect_valid, redirect_pc, id_ready
    );

    // Memory / execute / decode side
    modport slave (
        input  imem_req_valid, imem_req_addr, id_valid, id_pc, id_instr,
        output imem_req_ready, imem_rsp_valid, imem_rsp_data,
               redirect_valid, redirect_pc, id_ready
    );

endinterface

// File: rtl/rv32i_fetch_buf.sv
// In-order fetch buffer: entries are allocated at request accept, filled by
// responses in order and popped by decode. Flush drops every entry at once.
module rv32i_fetch_buf #(
    parameter int unsigned  XLEN  = 32,
    parameter int unsigned  DEPTH = 2,
    localparam int unsigned CNT_W = $clog2(DEPTH + 1)
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       flush_i,
    input  logic                       alloc_i,
    input  logic [XLEN-1:0]            alloc_pc_i,
    input  logic                       fill_i,
    input  logic [rv32i_pkg::ILEN-1:0] fill_data_i,
    input  logic                       pop_i,
    output logic [CNT_W-1:0]           count_o,
    output logic [CNT_W-1:0]           unfilled_o,
    output logic                       head_valid_o,
    output logic [XLEN-1:0]            head_pc_o,
    output logic [rv32i_pkg::ILEN-1:0] head_instr_o
);
    import rv32i_pkg::*;

    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [XLEN-1:0]  pc_q    [DEPTH];
    logic [ILEN-1:0]  instr_q [DEPTH];
    logic [DEPTH-1:0] filled_q, filled_d;
    logic [PTR_W-1:0] alloc_ptr_q, alloc_ptr_d;
    logic [PTR_W-1:0] fill_ptr_q, fill_ptr_d;
    logic [PTR_W-1:0] head_ptr_q, head_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic [CNT_W-1:0] unfilled_q, unfilled_d;

    // Pointer, occupancy and filled-flag update; flush clears the whole queue
    always_comb begin
        filled_d    = filled_q;
        alloc_ptr_d = alloc_ptr_q;
        fill_ptr_d  = fill_ptr_q;
        head_ptr_d  = head_ptr_q;
        count_d     = count_q;
        unfilled_d  = unfilled_q;
        if (flush_i) begin
            filled_d    = '0;
            alloc_ptr_d = '0;
            fill_ptr_d  = '0;
            head_ptr_d  = '0;
            count_d     = '0;
            unfilled_d  = '0;
        end else begin
            if (alloc_i) begin
                alloc_ptr_d = alloc_ptr_q + PTR_W'(1);
            end
            if (fill_i) begin
                filled_d[fill_ptr_q] = 1'b1;
                fill_ptr_d           = fill_ptr_q + PTR_W'(1);
            end
            if (pop_i) begin
                filled_d[head_ptr_q] = 1'b0;
                head_ptr_d           = head_ptr_q + PTR_W'(1);
            end
            count_d    = count_q + CNT_W'(alloc_i) - CNT_W'(pop_i);
            unfilled_d = unfilled_q + CNT_W'(alloc_i) - CNT_W'(fill_i);
        end
    end

    // Control state register
    always_ff @(posedge clk) begin
        if (rst) begin
            filled_q    <= '0;
            alloc_ptr_q <= '0;
            fill_ptr_q  <= '0;
            head_ptr_q  <= '0;
            count_q     <= '0;
            unfilled_q  <= '0;
        end else begin
            filled_q    <= filled_d;
            alloc_ptr_q <= alloc_ptr_d;
            fill_ptr_q  <= fill_ptr_d;
            head_ptr_q  <= head_ptr_d;
            count_q     <= count_d;
            unfilled_q  <= unfilled_d;
        end
    end

    // Entry payload: pc captured at allocation, instruction at fill
    always_ff @(posedge clk) begin
        if (rst) begin
            pc_q    <= '{default: '0};
            instr_q <= '{default: '0};
        end else begin
            if (alloc_i && !flush_i) begin
                pc_q[alloc_ptr_q] <= alloc_pc_i;
            end
            if (fill_i && !flush_i) begin
                instr_q[fill_ptr_q] <= fill_data_i;
            end
        end
    end

    assign count_o      = count_q;
    assign unfilled_o   = unfilled_q;
    assign head_valid_o = filled_q[head_ptr_q];
    assign head_pc_o    = pc_q[head_ptr_q];
    assign head_instr_o = instr_q[head_ptr_q];

endmodule

// File: rtl/rv32i_fetch.sv
// RV32I instruction fetch: PC, imem request issue, stale-response discard
// after redirect, and the decode-facing fetch buffer.
module rv32i_fetch #(
    parameter int unsigned     XLEN     = rv32i_pkg::XLEN,
    parameter logic [XLEN-1:0] RESET_PC = rv32i_pkg::RESET_PC,
    parameter int unsigned     FB_DEPTH = 2
) (
    input  logic          clk,
    input  logic          rst,
    rv32i_fetch_if.master bus
);
    import rv32i_pkg::*;

    localparam int unsigned CNT_W = $clog2(FB_DEPTH + 1);

    logic [XLEN-1:0]      pc_q, pc_d;
    logic [DISCARD_W-1:0] discard_q, discard_d;
    logic [CNT_W-1:0]     fb_count;
    logic [CNT_W-1:0]     fb_unfilled;
    logic                 fb_head_valid;
    logic [XLEN-1:0]      fb_head_pc;
    logic [ILEN-1:0]      fb_head_instr;
    logic                 req_valid_c;
    logic                 accept_c;
    logic                 fill_c;
    logic                 pop_c;
    logic                 unused_ok;

    // Handshake qualifiers; free space is judged on registered occupancy
    always_comb begin
        req_valid_c = (fb_count < CNT_W'(FB_DEPTH)) && !bus.redirect_valid && !rst;
        accept_c    = req_valid_c && bus.imem_req_ready;
        fill_c      = bus.imem_rsp_valid && (discard_q == '0) && !bus.redirect_valid;
        pop_c       = fb_head_valid && bus.id_ready && !bus.redirect_valid;
    end

    // Next PC and stale-response count. A response in the redirect cycle is
    // consumed either way: dropped against discard_q, or filling an entry
    // that the flush then kills.
    always_comb begin
        pc_d      = pc_q;
        discard_d = discard_q;
        if (bus.redirect_valid) begin
            pc_d      = {bus.redirect_pc[XLEN-1:2], 2'b00};
            discard_d = discard_q + DISCARD_W'(fb_unfilled)
                        - DISCARD_W'(bus.imem_rsp_valid);
        end else begin
            if (accept_c) begin
                pc_d = pc_q + XLEN'(4);
            end
            if (bus.imem_rsp_valid && (discard_q != '0)) begin
                discard_d = discard_q - DISCARD_W'(1);
            end
        end
    end

    // PC and discard counter registers
    always_ff @(posedge clk) begin
        if (rst) begin
            pc_q      <= RESET_PC;
            discard_q <= '0;
        end else begin
            pc_q      <= pc_d;
            discard_q <= discard_d;
        end
    end

    rv32i_fetch_buf #(
        .XLEN  (XLEN),
        .DEPTH (FB_DEPTH)
    ) u_buf (
        .clk          (clk),
        .rst          (rst),
        .flush_i      (bus.redirect_valid),
        .alloc_i      (accept_c),
        .alloc_pc_i   (pc_q),
        .fill_i       (fill_c),
        .fill_data_i  (bus.imem_rsp_data),
        .pop_i        (pop_c),
        .count_o      (fb_count),
        .unfilled_o   (fb_unfilled),
        .head_valid_o (fb_head_valid),
        .head_pc_o    (fb_head_pc),
        .head_instr_o (fb_head_instr)
    );

    assign bus.imem_req_valid = req_valid_c;
    assign bus.imem_req_addr  = pc_q;
    assign bus.id_valid       = fb_head_valid;
    assign bus.id_pc          = fb_head_pc;
    assign bus.id_instr       = fb_head_instr;

    // Redirect target alignment bits are ignored
    assign unused_ok = ^bus.redirect_pc[1:0];

endmodule
